full_mult: RTL and testbench
============================

// Module: full_mult
// PURPOSE
// - Complex 8x8 fixed-point matrix multiplier, C = A x B. Holds A (M1) and B (M2) in four internal RAMs: M1 real, M1 imag, M2 real, M2 imag.
// - After reset releases, it streams C row-major on one port, real or imaginary part selected by state.
// - Sits between the host loader (address/data/write-enable) and the downstream coefficient consumer.
// PARAMETERS
// - WORD_LEN   16  signed two's-complement word width of data and coefficient
// - ADDR_BITS  7   address port width; only 0..63 are valid
// - N          8   matrix dimension (N*N = 64 entries, row-major, addr = row*N + col)
// - FRAC_BITS  8   fractional bits of the Q format (0x0100 = 1.0)
// PORTS
// - src_clk       in   1          single clock; all logic is rising-edge
// - rst           in   1          synchronous, active-high reset
// - we            in   4          write enables: [0] M1 real, [1] M2 real, [2] M1 imag, [3] M2 imag
// - state         in   1          output select: `REAL_SET = 0 gives Re(C), `IMAG_SET = 1 gives Im(C)
// - data_m1_real  in   WORD_LEN   write data, M1 real RAM
// - data_m1_imag  in   WORD_LEN   write data, M1 imag RAM
// - data_m2_real  in   WORD_LEN   write data, M2 real RAM
// - data_m2_imag  in   WORD_LEN   write data, M2 imag RAM
// - Dir_M1        in   ADDR_BITS  write address for we[0] and we[2]
// - Dir_M2        in   ADDR_BITS  write address for we[1] and we[3]
// - coefficient   out  WORD_LEN   signed current C element, registered
// BEHAVIOUR
// RAM writes
// - Each we bit writes its RAM at the rising edge, independently; several bits may be set at once.
// - Writes are accepted regardless of rst.
// - Addresses >= 64 are ignored.
// - Reset never clears RAM contents.
// - Reads are asynchronous. A write at edge t is visible to the MAC from cycle t+1.
// Sequencer (counter, no FSM)
// - k = 0..7 is the inner index; n = 0..63 is the output element, with i = n/8 and j = n%8.
// - While rst = 1: k = 0, n = 0, acc = 0, coefficient = 0.
// - While rst = 0: one MAC per cycle, reading A[i][k] and B[k][j].
// - State latch: at k = 0, state is latched into sel for the whole element. A mid-element change of state takes effect on the next element.
// MAC terms
// - sel = REAL: term = Ar*Br - Ai*Bi
// - sel = IMAG: term = Ar*Bi + Ai*Br
// - Products are full 2*WORD_LEN width. acc is 2*WORD_LEN+4 bits signed.
// Element completion
// - k < 7: acc <= acc + term; k <= k+1.
// - k = 7: coefficient <= sat((acc + term) >>> FRAC_BITS); acc <= 0; k <= 0; n <= n+1.
// - sat clamps to 0x7FFF / 0x8000 (for WORD_LEN = 16). The shift is arithmetic (floor).
// Timing and boundaries
// - Latency: the first edge with rst = 0 is cycle 0. Element n appears after edge 8n+7 and holds for 8 cycles.
// - Wrap: after n = 63, n returns to 0. Streaming is continuous until rst.
// - Reset mid-element: the partial acc is discarded; output goes to 0 on the same edge.
// - Simultaneous write of an entry the MAC is reading in that cycle: the MAC uses the old value.
// STRUCTURE
// - Shared macro header: WORD_LEN, ADDR_BITS, REAL_SET, IMAG_SET.
// - One sub-module, mat_ram: 64 x WORD_LEN, 1 sync write port and 2 async read ports. Instantiated 4 times.
// - The top holds the sequencer, complex MAC and saturation.
// TESTING
// - Identity test: A real = 0x0100 on the diagonal, A imag = 0, B real[n] = n, B imag = 0. With REAL_SET -> coefficient = n for n = 0..63. With IMAG_SET -> all 0.
// - A imag = 0x0100 on the diagonal, A real = 0, B real[n] = n. With IMAG_SET -> coefficient = n. With REAL_SET -> 0.
// - A imag diagonal 0x0100, B imag all 0x0100, B real 0. With REAL_SET -> every coefficient = 0xFF00 (-1.0).
// - Saturation: A real = B real = 0x7FFF everywhere, imag 0 -> 0x7FFF. With A real = 0x8000 instead -> 0x8000.
// - Reset mid-stream: assert rst during element 5 -> coefficient = 0 on that edge. After release, element 0 appears after edge 7. RAM contents unchanged.
// - Timing: hold rst = 1 while loading all 256 words. Switch state during element 3 -> element 3 keeps the old part, element 4 uses the new part.

Source files
------------

// File: rtl/full_mult_pkg.sv
// full_mult_pkg: shared widths, output-select codes and saturation helper for full_mult
package full_mult_pkg;
  localparam int WORD_LEN = 16;
  localparam int ADDR_BITS = 7;
  localparam int N = 8;
  localparam int FRAC_BITS = 8;
  localparam int IDX_BITS = $clog2(N * N);
  localparam int K_BITS = $clog2(N);
  localparam int ACC_LEN = 2 * WORD_LEN + 4;
  localparam logic REAL_SET = 1'b0;
  localparam logic IMAG_SET = 1'b1;
  localparam logic signed [ACC_LEN-1:0] W_MAX = ACC_LEN'((1 << (WORD_LEN - 1)) - 1);
  localparam logic signed [ACC_LEN-1:0] W_MIN = -W_MAX - ACC_LEN'(1);
  function automatic logic [WORD_LEN-1:0] sat(input logic signed [ACC_LEN-1:0] v);
    logic signed [ACC_LEN-1:0] s;
    s = v >>> FRAC_BITS;
    return s > W_MAX ? W_MAX[WORD_LEN-1:0] : s < W_MIN ? W_MIN[WORD_LEN-1:0] : s[WORD_LEN-1:0];
  endfunction
endpackage

// File: rtl/mat_ram.sv
// mat_ram: 64-entry matrix store, one synchronous write port and two asynchronous read ports
module mat_ram
  import full_mult_pkg::*;
(
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [WORD_LEN-1:0]  wdata,
  input  logic [IDX_BITS-1:0]  raddr_a,
  input  logic [IDX_BITS-1:0]  raddr_b,
  output logic [WORD_LEN-1:0]  rdata_a,
  output logic [WORD_LEN-1:0]  rdata_b
);
  logic [WORD_LEN-1:0] mem [N*N];
  always_ff @(posedge clk)
    if (we && waddr < ADDR_BITS'(N * N)) mem[waddr[IDX_BITS-1:0]] <= wdata;
  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];
endmodule

// File: rtl/full_mult.sv
// full_mult: streams C = A x B (complex 8x8, Q8.8) row-major, one MAC per cycle, 8 cycles per element
module full_mult
  import full_mult_pkg::*;
(
  input  logic                 src_clk,
  input  logic                 rst,
  input  logic [3:0]           we,
  input  logic                 state,
  input  logic [WORD_LEN-1:0]  data_m1_real,
  input  logic [WORD_LEN-1:0]  data_m1_imag,
  input  logic [WORD_LEN-1:0]  data_m2_real,
  input  logic [WORD_LEN-1:0]  data_m2_imag,
  input  logic [ADDR_BITS-1:0] Dir_M1,
  input  logic [ADDR_BITS-1:0] Dir_M2,
  output logic [WORD_LEN-1:0]  coefficient
);
  logic [K_BITS-1:0] k;
  logic [IDX_BITS-1:0] n, addr_a, addr_b;
  logic sel, use_imag;
  logic signed [ACC_LEN-1:0] acc, term, sum;
  logic signed [2*WORD_LEN-1:0] p_rr, p_ii, p_ri, p_ir;
  logic [WORD_LEN-1:0] wd [4];
  logic [ADDR_BITS-1:0] wa [4];
  logic signed [WORD_LEN-1:0] rd [4];
  logic [WORD_LEN-1:0] unused_rd [4];
  // index order matches we: M1 real, M2 real, M1 imag, M2 imag
  assign wd[0] = data_m1_real;
  assign wd[1] = data_m2_real;
  assign wd[2] = data_m1_imag;
  assign wd[3] = data_m2_imag;
  assign addr_a = {n[IDX_BITS-1:K_BITS], k};
  assign addr_b = {k, n[K_BITS-1:0]};
  for (genvar g = 0; g < 4; g++) begin : g_ram
    assign wa[g] = (g % 2 == 1) ? Dir_M2 : Dir_M1;
    mat_ram u_ram (
      .clk     (src_clk),
      .we      (we[g]),
      .waddr   (wa[g]),
      .wdata   (wd[g]),
      .raddr_a ((g % 2 == 1) ? addr_b : addr_a),
      .raddr_b ('0),
      .rdata_a (rd[g]),
      .rdata_b (unused_rd[g])
    );
  end
  // the element's first MAC sees state directly; the rest use the latched copy
  assign use_imag = (k == '0) ? state : sel;
  assign p_rr = (2*WORD_LEN)'(rd[0]) * (2*WORD_LEN)'(rd[1]);
  assign p_ii = (2*WORD_LEN)'(rd[2]) * (2*WORD_LEN)'(rd[3]);
  assign p_ri = (2*WORD_LEN)'(rd[0]) * (2*WORD_LEN)'(rd[3]);
  assign p_ir = (2*WORD_LEN)'(rd[2]) * (2*WORD_LEN)'(rd[1]);
  always_comb begin
    term = (use_imag == IMAG_SET) ? ACC_LEN'(p_ri) + ACC_LEN'(p_ir) : ACC_LEN'(p_rr) - ACC_LEN'(p_ii);
    sum = acc + term;
  end
  always_ff @(posedge src_clk)
    if (rst) begin
      k <= '0;
      n <= '0;
      acc <= '0;
      sel <= REAL_SET;
      coefficient <= '0;
    end else begin
      if (k == '0) sel <= state;
      k <= k + 1'b1;
      if (k == K_BITS'(N - 1)) begin
        coefficient <= sat(sum);
        acc <= '0;
        n <= n + 1'b1;
      end else begin
        acc <= sum;
      end
    end
endmodule

// File: tb/tb_full_mult.sv
// tb_full_mult: scoreboard bench; stimulus queues expected elements, the monitor checks each one as it appears
module tb_full_mult;
  logic src_clk = 0, rst = 1, state = 0;
  logic [3:0] we = '0;
  logic [15:0] data_m1_real = '0, data_m1_imag = '0, data_m2_real = '0, data_m2_imag = '0;
  logic [6:0] Dir_M1 = '0, Dir_M2 = '0;
  logic [15:0] coefficient;
  logic [15:0] q [$];
  int checks = 0, fails = 0, cyc = 0;

  full_mult dut (
    .src_clk(src_clk), .rst(rst), .we(we), .state(state),
    .data_m1_real(data_m1_real), .data_m1_imag(data_m1_imag),
    .data_m2_real(data_m2_real), .data_m2_imag(data_m2_imag),
    .Dir_M1(Dir_M1), .Dir_M2(Dir_M2), .coefficient(coefficient)
  );

  always #5 src_clk = ~src_clk;

  always @(posedge src_clk) begin
    logic r;
    logic [15:0] e;
    r = rst;
    #1;
    if (r) begin
      cyc = 0;
      checks++;
      if (coefficient !== 16'h0) begin
        fails++;
        $display("FAIL reset_out: got %h want 0000", coefficient);
      end
    end else begin
      if (cyc % 8 == 7 && q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (coefficient !== e) begin
          fails++;
          $display("FAIL element %0d (cycle %0d): got %h want %h", cyc / 8, cyc, coefficient, e);
        end
      end
      cyc++;
    end
  end

  task automatic wr(input int a, input logic [15:0] ar, br, ai, bi);
    Dir_M1 = 7'(a);
    Dir_M2 = 7'(a);
    data_m1_real = ar;
    data_m2_real = br;
    data_m1_imag = ai;
    data_m2_imag = bi;
    we = 4'hF;
    @(negedge src_clk);
    we = '0;
  endtask

  // kind: 0 identity/Br=n/Bi=-n, 1 Ai diag/Br=n, 2 Ai diag/Bi=1.0, 3 +max sat, 4 -max sat
  task automatic load(input int kind);
    for (int a = 0; a < 64; a++) begin
      logic [15:0] d;
      d = (a / 8 == a % 8) ? 16'h0100 : 16'h0000;
      case (kind)
        0: wr(a, d, 16'(a), 16'h0, 16'(-a));
        1: wr(a, 16'h0, 16'(a), d, 16'h0);
        2: wr(a, 16'h0, 16'h0, d, 16'h0100);
        3: wr(a, 16'h7FFF, 16'h7FFF, 16'h0, 16'h0);
        default: wr(a, 16'h8000, 16'h7FFF, 16'h0, 16'h0);
      endcase
    end
  endtask

  task automatic push_const(input int cnt, input logic [15:0] v);
    for (int i = 0; i < cnt; i++) q.push_back(v);
  endtask

  task automatic start(input logic st);
    state = st;
    rst = 0;
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() > 0 && t < 3000) begin
      @(negedge src_clk);
      t++;
    end
    if (q.size() > 0) begin
      checks++;
      fails++;
      $display("FAIL drain timeout: %0d elements outstanding, want 0", q.size());
      q.delete();
    end
  endtask

  task automatic stop();
    rst = 1;
    @(negedge src_clk);
  endtask

  initial begin
    repeat (3) @(negedge src_clk);
    load(0);
    wr(64, 16'h7777, 16'h7777, 16'h7777, 16'h7777);
    for (int n = 0; n < 67; n++) q.push_back(n < 4 ? 16'(n) : 16'(-(n % 64)));
    start(1'b0);
    repeat (27) @(negedge src_clk);
    state = 1'b1;
    drain();
    stop();
    for (int n = 0; n < 5; n++) q.push_back(16'(n));
    start(1'b0);
    drain();
    repeat (3) @(negedge src_clk);
    stop();
    for (int n = 0; n < 8; n++) q.push_back(16'(n));
    start(1'b0);
    drain();
    stop();
    load(1);
    for (int n = 0; n < 64; n++) q.push_back(16'(n));
    start(1'b1);
    drain();
    stop();
    push_const(8, 16'h0000);
    start(1'b0);
    drain();
    stop();
    load(2);
    push_const(8, 16'hFF00);
    start(1'b0);
    drain();
    stop();
    push_const(8, 16'h0000);
    start(1'b1);
    drain();
    stop();
    load(3);
    push_const(8, 16'h7FFF);
    start(1'b0);
    drain();
    stop();
    load(4);
    push_const(8, 16'h8000);
    start(1'b0);
    drain();
    stop();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
